// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration state and read-return owner tag.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        S_SHARED,
        S_HOST_LOCK
    } arbState_e;

    typedef enum logic [1:0] {
        NONE,
        CORE,
        HOST
    } rdOwner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core memory stage and the host port.
// Grants one requester per cycle, bounds host starvation, supports host lock bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,

    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arbState_e        stateQ, stateD;
    rdOwner_e         rdOwnerQ, rdOwnerD;
    logic [CNT_W-1:0] starveCntQ, starveCntD;

    logic coreGnt;
    logic hostGnt;
    logic starveFull;
    logic lockHeld;

    assign starveFull = (starveCntQ == CNT_MAX);
    // Lock only holds while the host keeps both req and lock high; otherwise the
    // release is visible in the same cycle and normal arbitration applies.
    assign lockHeld   = (stateQ == S_HOST_LOCK) && host_req && host_lock;

    always_comb begin
        hostGnt    = 1'b0;
        coreGnt    = 1'b0;
        stateD     = S_SHARED;
        starveCntD = starveCntQ;
        rdOwnerD   = NONE;

        if (!rst) begin
            if (lockHeld) begin
                hostGnt = 1'b1;
            end else begin
                hostGnt = host_req && (!core_req || starveFull);
                coreGnt = core_req && !hostGnt;
            end
        end

        if (hostGnt && host_lock) begin
            stateD = S_HOST_LOCK;
        end

        if (!host_req || hostGnt) begin
            starveCntD = '0;
        end else if (!starveFull) begin
            starveCntD = starveCntQ + CNT_W'(1);
        end

        if (coreGnt && !core_we) begin
            rdOwnerD = CORE;
        end else if (hostGnt && !host_we) begin
            rdOwnerD = HOST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= S_SHARED;
            starveCntQ <= '0;
            rdOwnerQ   <= NONE;
        end else begin
            stateQ     <= stateD;
            starveCntQ <= starveCntD;
            rdOwnerQ   <= rdOwnerD;
        end
    end

    // Losing requester is fully masked so its address/data never reach memory.
    always_comb begin
        mem_en    = coreGnt || hostGnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (hostGnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (coreGnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    assign core_stall  = core_req && !coreGnt && !rst;
    assign host_gnt    = hostGnt;

    assign core_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign core_rvalid = (rdOwnerQ == CORE) && !rst;
    assign host_rvalid = (rdOwnerQ == HOST) && !rst;

endmodule
